// File: rtl/moving_sum_inverse.sv
// rtl/moving_sum_inverse.sv - recovers raw samples from a sliding-window running-sum stream
module moving_sum_inverse #(
  parameter int N          = 15,
  parameter int DATA_WIDTH = 10,
  parameter int SUM_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sum_valid,
  input  logic signed [SUM_WIDTH-1:0]  i_sum_in,
  output logic                         o_dout_valid,
  output logic signed [DATA_WIDTH-1:0] o_dout,
  output logic                         o_primed,
  output logic                         o_ovf
);

  localparam int DW = DATA_WIDTH;
  localparam int WW = SUM_WIDTH + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic signed [WW-1:0] MAXV = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0]        r_hist [N];
  logic signed [SUM_WIDTH-1:0] r_s_prev;
  logic [CW-1:0]               r_cnt;
  logic signed [DW-1:0]        r_dout;
  logic                        r_dout_valid;
  logic                        r_ovf;

  logic signed [WW-1:0] w_sum_ext;
  logic signed [WW-1:0] w_prev_ext;
  logic signed [WW-1:0] w_old_ext;
  logic signed [WW-1:0] w_d;
  logic signed [DW-1:0] w_x;
  logic                 w_sat;

  // Wide intermediate keeps the difference exact; clamping is the only alteration.
  assign w_sum_ext  = {{2{i_sum_in[SUM_WIDTH-1]}}, i_sum_in};
  assign w_prev_ext = {{2{r_s_prev[SUM_WIDTH-1]}}, r_s_prev};
  assign w_old_ext  = {{(WW-DW){r_hist[N-1][DW-1]}}, r_hist[N-1]};
  assign w_d        = w_sum_ext - w_prev_ext + w_old_ext;

  always_comb begin
    w_x   = w_d[DW-1:0];
    w_sat = 1'b0;
    if (w_d > MAXV) begin
      w_x   = MAXV[DW-1:0];
      w_sat = 1'b1;
    end else if (w_d < MINV) begin
      w_x   = MINV[DW-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) r_hist[i] <= '0;
      r_s_prev     <= '0;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_dout_valid <= i_sum_valid;
      if (i_sum_valid) begin
        for (int i = N - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
        r_hist[0] <= w_x;
        r_dout    <= w_x;
        r_s_prev  <= i_sum_in;
        if (r_cnt != CNT_FULL) r_cnt <= r_cnt + 1'b1;
        if (w_sat) r_ovf <= 1'b1;
      end
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_ovf        = r_ovf;
  assign o_primed     = (r_cnt == CNT_FULL);

endmodule

// File: doc/moving_sum_inverse.md
# moving_sum_inverse

Reconstructs the original sample stream from a sliding-window running-sum stream of window N: the inverse of the moving-average filter's accumulator. Each running-sum value produces one recovered sample, using x[n] = S[n] − S[n−1] + x[n−N]. It sits on the receive side of the filter link and recovers the raw input sequence, either for loopback verification of the filter or for downstream consumers that need raw samples. It keeps an N-deep history of recovered samples, a previous-sum register, a priming counter and a sticky overflow flag.

## Interface
- N, 15: window size of the matching forward filter; ≥ 2.
- DATA_WIDTH, 10: width of a recovered sample, signed.
- SUM_WIDTH, DATA_WIDTH+4: width of the incoming running sum, signed.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- sum_valid  in  1  sum_in is valid this cycle.
- sum_in  in  SUM_WIDTH  signed running sum S[n] of the last N samples.
- dout_valid  out  1  dout holds a new recovered sample this cycle.
- dout  out  DATA_WIDTH  signed recovered sample x[n].
- primed  out  1  N or more samples have been recovered since reset.
- ovf  out  1  sticky; a recovered value needed saturation since reset.

## Operation
- State:
  - history hist[0..N-1] of DATA_WIDTH signed values; hist[0] is the newest.
  - s_prev, SUM_WIDTH signed.
  - cnt, 0..N, saturating.
  - ovf register.
- Reset (async, rst=1): hist all 0; s_prev=0; cnt=0; dout=0; dout_valid=0; primed=0; ovf=0. These values are held while rst is high.
- Accepted sample (sum_valid=1), in a single cycle:
  - Compute d = sum_in − s_prev + hist[N-1] at width SUM_WIDTH+2, with every operand sign-extended.
  - Saturate d to the DATA_WIDTH signed range, giving x = clamp(d, −2^(DW−1), 2^(DW−1)−1). If d ≠ x, set ovf.
  - Register dout ← x and dout_valid ← 1.
  - Shift hist (hist[i] ← hist[i−1]) and load hist[0] ← x. The saturated value is stored, not d.
  - s_prev ← sum_in.
  - cnt ← min(cnt+1, N).
- Idle cycle (sum_valid=0): dout_valid ← 0. dout, hist, s_prev, cnt and ovf all hold.
- primed = (cnt == N). It is combinational from cnt and never deasserts except on reset.
- There is no backpressure: every valid sum produces exactly one output. Gaps in sum_valid of any length are transparent.
- Exact reconstruction is guaranteed when the forward filter and this block both come out of reset together and see the same sample sequence with the same N.
- Non-matching input streams are still processed by the same rule. Saturation keeps dout bounded.

## Timing
- Latency is 1 cycle: a sum accepted at edge k yields dout/dout_valid valid after edge k and until edge k+1.
- Throughput is one sample per cycle. Back-to-back sum_valid is supported with no bubble.
- dout_valid is a single-cycle pulse per accepted sum.
- ovf asserts in the same cycle as the saturated dout and stays high until rst.
- primed rises in the same cycle as the dout_valid pulse of the Nth accepted sample.
- Reset mid-stream:
  - Outputs clear immediately, asynchronously.
  - The first sum_valid after rst deasserts is treated as sample 0 with zero history.
  - A sum_valid on the cycle rst deasserts is accepted normally.
- Arithmetic: there is no wrap-around in the difference path, because of the SUM_WIDTH+2 intermediate. Saturation is the only way a value is altered.

## Test plan
- **Impulse** (N=15, DW=10): after reset, feed sum_in 100 for 15 valid cycles, then 0 for 20 cycles. Required: dout=100 on the first pulse and 0 on every other pulse. primed rises on the 15th pulse. ovf stays 0.
- **Ramp of constant input**: feed sum_in 5, 10, …, 75, then 75 repeated 10 times, back-to-back. Required: every dout = 5, each pulse exactly one cycle after its input.
- **Gapped valid**: repeat the impulse test with sum_valid low on every other cycle. Required: the same dout sequence as the impulse test. dout_valid is low in the gap cycles and dout holds its value there.
- **Saturation**:
  - After reset, feed sum_in 1000. Required: dout=511, ovf=1.
  - Next feed sum_in 0. Required: d=−1000, so dout=−512; ovf stays 1.
- **Reset mid-operation**: assert rst after 7 valid samples of the ramp test, with sum_valid still driven. Required: dout, dout_valid, primed and ovf go 0 immediately. After release, feeding sum_in 5 gives dout=5.
- **Random loopback**: drive random DATA_WIDTH samples through a forward running-sum model, with N=15 and random valid gaps, into this block. Required: dout matches the original samples exactly over ≥ 10000 samples, and ovf=0.
